// File: rtl/btn_pkg.sv
`default_nettype none
// ============================================================================
// Module : btn_pkg
// Brief  : Shared key indices, widths and repeat-FSM state type.
// Rev    : 1.0
// ============================================================================
package btn_pkg;

   localparam int KEY_ROT   = 0;
   localparam int KEY_LEFT  = 1;
   localparam int KEY_RIGHT = 2;
   localparam int KEY_DOWN  = 3;
   localparam int KEY_DROP  = 4;

   localparam int NUM_KEYS = 5;
   localparam int CODE_W   = $clog2(NUM_KEYS);
   localparam logic [NUM_KEYS-1:0] REPEAT_MASK = 5'b00111;

   typedef enum logic [1:0] {
      RPT_IDLE   = 2'd0,
      RPT_DELAY  = 2'd1,
      RPT_REPEAT = 2'd2
   } rpt_state_t;

endpackage
`default_nettype wire

// File: rtl/btn_cmd_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : btn_cmd_arbiter_if
// Brief  : Button inputs and engine-facing command handshake.
// Rev    : 1.0
// ============================================================================
interface btn_cmd_arbiter_if #(
   parameter int NUM_KEYS   = btn_pkg::NUM_KEYS,
   parameter int FIFO_DEPTH = 4
) ();
   localparam int CODE_W  = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
   localparam int COUNT_W = $clog2(FIFO_DEPTH) + 1;

   logic [NUM_KEYS-1:0] key_pulse;
   logic [NUM_KEYS-1:0] key_held;
   logic                cmd_valid;
   logic                cmd_ready;
   logic [CODE_W-1:0]   cmd_code;
   logic [COUNT_W-1:0]  fifo_count;
   logic                ovf;
   logic                clr_ovf;

   modport master (
      input  key_pulse, key_held, cmd_ready, clr_ovf,
      output cmd_valid, cmd_code, fifo_count, ovf
   );

   modport slave (
      output key_pulse, key_held, cmd_ready, clr_ovf,
      input  cmd_valid, cmd_code, fifo_count, ovf
   );
endinterface
`default_nettype wire

// File: rtl/cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module : cmd_fifo
// Brief  : First-word-fall-through FIFO with occupancy count.
// Rev    : 1.0
// ============================================================================
module cmd_fifo #(
   parameter int WIDTH = 3,
   parameter int DEPTH = 4
) (
   input  wire logic                     clk,
   input  wire logic                     rst,
   input  wire logic                     i_push,
   input  wire logic [WIDTH-1:0]         i_data,
   input  wire logic                     i_pop,
   output logic                          o_valid,
   output logic [WIDTH-1:0]              o_data,
   output logic [$clog2(DEPTH):0]        o_count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic [WIDTH-1:0] r_last;
   logic             w_pop;
   logic             w_push;

   assign w_pop  = i_pop && (r_count != '0);
   assign w_push = i_push && ((r_count < (AW+1)'(DEPTH)) || w_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_last   <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
            r_last   <= r_mem[r_rd_ptr];
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

   // When empty, present the last popped code so the output does not wander.
   assign o_valid = (r_count != '0);
   assign o_data  = o_valid ? r_mem[r_rd_ptr] : r_last;
   assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/btn_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module : btn_cmd_arbiter
// Brief  : Per-key auto-repeat, fixed-priority arbiter and command FIFO.
// Rev    : 1.0
// ============================================================================
module btn_cmd_arbiter #(
   parameter int                  NUM_KEYS      = btn_pkg::NUM_KEYS,
   parameter int                  REPEAT_DELAY  = 12_500_000,
   parameter int                  REPEAT_PERIOD = 2_500_000,
   parameter logic [NUM_KEYS-1:0] REPEAT_MASK   = btn_pkg::REPEAT_MASK,
   parameter int                  FIFO_DEPTH    = 4,
   parameter int                  CNT_W         = 24
) (
   input  wire logic           clk,
   input  wire logic           rst,
   btn_cmd_arbiter_if.master   if_cmd
);
   import btn_pkg::*;

   localparam int CODE_W  = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
   localparam int COUNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_W-1:0] c_delay_last  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] c_period_last = CNT_W'(REPEAT_PERIOD - 1);

   logic [NUM_KEYS-1:0] w_tick;
   logic [NUM_KEYS-1:0] w_event;
   logic [NUM_KEYS-1:0] r_pend;
   logic [NUM_KEYS-1:0] w_grant;
   logic [NUM_KEYS-1:0] w_merge;
   logic [CODE_W-1:0]   w_grant_code;
   logic                w_any_grant;
   logic                w_push_ok;
   logic                r_ovf;
   logic                w_fifo_valid;
   logic [CODE_W-1:0]   w_fifo_code;
   logic [COUNT_W-1:0]  w_fifo_count;

   for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
      if (REPEAT_MASK[k]) begin : g_rpt
         rpt_state_t       r_state;
         rpt_state_t       w_state_nxt;
         logic [CNT_W-1:0] r_cnt;
         logic [CNT_W-1:0] w_cnt_nxt;
         logic             w_tk;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_state <= RPT_IDLE;
               r_cnt   <= '0;
            end else begin
               r_state <= w_state_nxt;
               r_cnt   <= w_cnt_nxt;
            end
         end

         // A fresh press always restarts the initial delay, even mid-repeat.
         always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_tk        = 1'b0;
            if (if_cmd.key_pulse[k]) begin
               w_state_nxt = RPT_DELAY;
               w_cnt_nxt   = '0;
            end else begin
               case (r_state)
                  RPT_DELAY: begin
                     if (!if_cmd.key_held[k]) begin
                        w_state_nxt = RPT_IDLE;
                        w_cnt_nxt   = '0;
                     end else if (r_cnt == c_delay_last) begin
                        w_tk        = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = RPT_REPEAT;
                     end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                     end
                  end
                  RPT_REPEAT: begin
                     if (!if_cmd.key_held[k]) begin
                        w_state_nxt = RPT_IDLE;
                        w_cnt_nxt   = '0;
                     end else if (r_cnt == c_period_last) begin
                        w_tk      = 1'b1;
                        w_cnt_nxt = '0;
                     end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                     end
                  end
                  default: begin
                     w_state_nxt = RPT_IDLE;
                     w_cnt_nxt   = '0;
                  end
               endcase
            end
         end

         assign w_tick[k] = w_tk;
      end else begin : g_norpt
         assign w_tick[k] = 1'b0;
      end
   end

   assign w_event   = if_cmd.key_pulse | w_tick;
   assign w_push_ok = (w_fifo_count < COUNT_W'(FIFO_DEPTH)) ||
                      (w_fifo_valid && if_cmd.cmd_ready);

   // Descending scan so the lowest pending index wins.
   always_comb begin
      w_grant      = '0;
      w_grant_code = '0;
      w_any_grant  = 1'b0;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (r_pend[i] && w_push_ok) begin
            w_grant      = '0;
            w_grant[i]   = 1'b1;
            w_grant_code = CODE_W'(i);
            w_any_grant  = 1'b1;
         end
      end
   end

   assign w_merge = w_event & r_pend & ~w_grant;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pend <= '0;
         r_ovf  <= 1'b0;
      end else begin
         r_pend <= (r_pend & ~w_grant) | w_event;
         if (|w_merge)           r_ovf <= 1'b1;
         else if (if_cmd.clr_ovf) r_ovf <= 1'b0;
      end
   end

   cmd_fifo #(
      .WIDTH (CODE_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_any_grant),
      .i_data  (w_grant_code),
      .i_pop   (if_cmd.cmd_ready),
      .o_valid (w_fifo_valid),
      .o_data  (w_fifo_code),
      .o_count (w_fifo_count)
   );

   assign if_cmd.cmd_valid  = w_fifo_valid;
   assign if_cmd.cmd_code   = w_fifo_code;
   assign if_cmd.fifo_count = w_fifo_count;
   assign if_cmd.ovf        = r_ovf;

endmodule
`default_nettype wire
